// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg
// Shared definitions for the instruction-fetch front end: parcel width,
// the RVC opcode mask and the helper that classifies a 16-bit parcel.
// No ports (package).
package fetch_queue_pkg;

    localparam int         PARCEL_W = 16;
    localparam logic [1:0] RVC_MASK = 2'b11;

    // A parcel starts a compressed instruction unless its two low bits are 11.
    function automatic logic is_compressed(input logic [PARCEL_W-1:0] parcel);
        return (parcel[1:0] & RVC_MASK) != RVC_MASK;
    endfunction

endpackage

// File: rtl/fetch_queue_halfword_fifo.sv
// halfword_fifo
// Circular buffer of 2*DEPTH 16-bit parcels. Up to two parcels can be pushed
// and up to two popped per cycle; flush empties it. The two oldest parcels
// are visible combinationally on head0/head1.
// Ports:
//   clock, reset_n          clock and asynchronous active-low reset
//   flush                   discard all contents (wins over push/pop)
//   push_n, push_data0/1    number of parcels to push (0..2), oldest first
//   pop_n                   number of parcels to pop (0..2)
//   head0, head1            oldest and second-oldest parcel
//   count                   parcels currently held
module halfword_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           flush,
    input  logic [1:0]                     push_n,
    input  logic [PARCEL_W-1:0]            push_data0,
    input  logic [PARCEL_W-1:0]            push_data1,
    input  logic [1:0]                     pop_n,
    output logic [PARCEL_W-1:0]            head0,
    output logic [PARCEL_W-1:0]            head1,
    output logic [$clog2(2*DEPTH+1)-1:0]   count
);

    localparam int SLOTS = 2 * DEPTH;
    localparam int PTR_W = $clog2(SLOTS);
    localparam int CNT_W = $clog2(SLOTS + 1);
    localparam logic [PTR_W:0] SLOTS_P = (PTR_W + 1)'(SLOTS);

    logic [PARCEL_W-1:0] mem_q [SLOTS];
    logic [PARCEL_W-1:0] mem_d [SLOTS];
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    // Pointer advance with explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                 input logic [1:0]       n);
        logic [PTR_W:0] s;
        s = {1'b0, p} + (PTR_W + 1)'(n);
        if (s >= SLOTS_P) s = s - SLOTS_P;
        return s[PTR_W-1:0];
    endfunction

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_n != 2'd0) mem_d[wr_ptr_q] = push_data0;
            if (push_n == 2'd2) mem_d[ptr_add(wr_ptr_q, 2'd1)] = push_data1;
            wr_ptr_d = ptr_add(wr_ptr_q, push_n);
            rd_ptr_d = ptr_add(rd_ptr_q, pop_n);
            count_d  = count_q + CNT_W'(push_n) - CNT_W'(pop_n);
        end
    end

    // Parcel storage carries no reset; only the pointers and count do.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head0 = mem_q[rd_ptr_q];
    assign head1 = mem_q[ptr_add(rd_ptr_q, 2'd1)];
    assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue
// Instruction-fetch front end with a prefetch buffer. Fetches aligned 32-bit
// words from l1i (one request in flight), splits them into 16-bit parcels in
// a halfword queue, realigns RVC and 32-bit instructions (including ones that
// straddle a word boundary) and presents one instruction per handshake.
// A redirect flushes the queue and discards any in-flight response.
// Ports:
//   clock, reset_n                          clock, asynchronous active-low reset
//   mem_req_valid/address/ready             word fetch request to l1i
//   mem_resp_valid/data                     response word (little-endian)
//   redirect_valid/pc                       taken branch/jump, new halfword PC
//   out_valid/ready                         instruction handshake to decode
//   out_instruction, out_pc, out_is_compact instruction, its PC, 16-bit flag
//   queue_count                             parcels held (debug)
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int             XLEN          = 32,
    parameter int             DEPTH         = 4,
    parameter logic [XLEN-1:0] RESET_PC     = '0,
    parameter bit             COMPRESSED_EN = 1'b1
) (
    input  logic                         clock,
    input  logic                         reset_n,
    output logic                         mem_req_valid,
    output logic [XLEN-1:0]              mem_req_address,
    input  logic                         mem_req_ready,
    input  logic                         mem_resp_valid,
    input  logic [31:0]                  mem_resp_data,
    input  logic                         redirect_valid,
    input  logic [XLEN-1:0]              redirect_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_instruction,
    output logic [XLEN-1:0]              out_pc,
    output logic                         out_is_compact,
    output logic [$clog2(2*DEPTH+1)-1:0] queue_count
);

    localparam int SLOTS = 2 * DEPTH;
    localparam int CNT_W = $clog2(SLOTS + 1);
    // A request needs room for a full word (two parcels).
    localparam logic [CNT_W-1:0] REQ_LIMIT = CNT_W'(SLOTS - 2);

    logic [XLEN-1:0]     fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]     head_pc_q, head_pc_d;
    logic                skip_low_q, skip_low_d;
    logic                outstanding_q, outstanding_d;
    logic                drop_q, drop_d;

    logic [PARCEL_W-1:0] head0, head1;
    logic [CNT_W-1:0]    count;
    logic                one_parcel, avail, req_ok, fire, resp_accept;
    logic [1:0]          push_n, pop_n;
    logic [PARCEL_W-1:0] push_data0, push_data1;

    halfword_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .flush      (redirect_valid),
        .push_n     (push_n),
        .push_data0 (push_data0),
        .push_data1 (push_data1),
        .pop_n      (pop_n),
        .head0      (head0),
        .head1      (head1),
        .count      (count)
    );

    always_comb begin
        // Zero parcel also takes the one-parcel path; it is just not flagged compact.
        one_parcel  = COMPRESSED_EN && is_compressed(head0);
        avail       = one_parcel ? (count != '0) : (count >= CNT_W'(2));
        // No request in the redirect cycle: fetch_pc is about to be replaced.
        req_ok      = !outstanding_q && !drop_q && (count <= REQ_LIMIT) && !redirect_valid;
        fire        = req_ok && mem_req_ready;
        resp_accept = mem_resp_valid && outstanding_q;

        pop_n  = (avail && out_ready && !redirect_valid) ? (one_parcel ? 2'd1 : 2'd2) : 2'd0;
        push_n = (resp_accept && !drop_q && !redirect_valid) ? (skip_low_q ? 2'd1 : 2'd2) : 2'd0;
        // After a redirect to pc[1]=1 the low parcel of the first word is not wanted.
        push_data0 = skip_low_q ? mem_resp_data[31:16] : mem_resp_data[15:0];
        push_data1 = mem_resp_data[31:16];
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        head_pc_d     = head_pc_q;
        skip_low_d    = skip_low_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        if (redirect_valid) begin
            fetch_pc_d    = {redirect_pc[XLEN-1:2], 2'b00};
            head_pc_d     = redirect_pc;
            skip_low_d    = redirect_pc[1];
            // A response landing in this very cycle is simply ignored; one still
            // in flight must be dropped when it arrives.
            outstanding_d = outstanding_q && !mem_resp_valid;
            drop_d        = outstanding_q && !mem_resp_valid;
        end else begin
            head_pc_d = head_pc_q + {{(XLEN-3){1'b0}}, pop_n, 1'b0};
            if (resp_accept) begin
                outstanding_d = 1'b0;
                if (drop_q) drop_d = 1'b0;
                else        skip_low_d = 1'b0;
            end
            if (fire) begin
                outstanding_d = 1'b1;
                fetch_pc_d    = fetch_pc_q + XLEN'(4);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q    <= {RESET_PC[XLEN-1:2], 2'b00};
            head_pc_q     <= RESET_PC;
            skip_low_q    <= RESET_PC[1];
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            head_pc_q     <= head_pc_d;
            skip_low_q    <= skip_low_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    // Outputs are forced to zero while reset is asserted.
    always_comb begin
        mem_req_valid   = reset_n && req_ok;
        mem_req_address = reset_n ? {fetch_pc_q[XLEN-1:2], 2'b00} : '0;
        out_valid       = reset_n && avail;
        out_instruction = '0;
        if (reset_n) out_instruction = one_parcel ? {16'h0000, head0} : {head1, head0};
        out_pc          = reset_n ? head_pc_q : '0;
        out_is_compact  = reset_n && one_parcel && (head0 != '0);
        queue_count     = reset_n ? count : '0;
    end

endmodule
